// File: rtl/comp_seq_ctrl_if.sv
// Board-side bundle for the comparator sequencer: buttons and switch nibble in, operands/result/status out.
// The controller takes the slave view; the board or bench drives through the master view.
// No backpressure; every signal is a plain level.
interface comp_seq_ctrl_if;
    logic [3:0] pb;
    logic [3:0] q;
    logic [7:0] a;
    logic [7:0] b;
    logic       lo;
    logic       eo;
    logic       go;
    logic       valid;
    logic       err;
    logic [2:0] state;

    modport slave (
        input  pb, q,
        output a, b, lo, eo, go, valid, err, state
    );

    modport master (
        output pb, q,
        input  a, b, lo, eo, go, valid, err, state
    );
endinterface

// File: rtl/comp_seq_ctrl.sv
// Pushbutton sequencer: debounces pb1..pb4, captures q as A[7:4],A[3:0],B[7:4],B[3:0], then registers lo/eo/go.
// Latency: raw press to register update is 2 + DEB_CYCLES + 1 cycles (+/-1 synchronizer phase).
// No backpressure: out-of-order or simultaneous presses abort to IDLE with err; COMP_SEQ_TIMEOUT_EN adds an idle abort.
module comp_seq_ctrl #(
    parameter int DEB_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic         clk,
    input  logic         rst_n,
    comp_seq_ctrl_if.slave bus
);

    localparam int DW = $clog2(DEB_CYCLES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GOT_AH = 3'd1,
        GOT_AL = 3'd2,
        GOT_BH = 3'd3,
        DONE   = 3'd4
    } state_t;

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_deb;
    logic [3:0]    r_deb_d;
    logic [DW-1:0] r_cnt [4];

    state_t        r_state;
    logic [7:0]    r_a;
    logic [7:0]    r_b;
    logic          r_lo;
    logic          r_eo;
    logic          r_go;
    logic          r_valid;
    logic          r_err;

    logic [3:0]    w_pulse;
    logic          w_any;
    logic          w_multi;
    logic          w_accept;
    logic [7:0]    w_b_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb_d <= '0;
        end else begin
            r_sync1 <= bus.pb;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
        end
    end

    // Counter advances only while the synchronized input disagrees with the debounced level,
    // so any bounce back to the old level restarts the qualification window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb <= '0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                        r_deb[i] <= ~r_deb[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + DW'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_pulse  = r_deb & ~r_deb_d;
    assign w_any    = |w_pulse;
    assign w_multi  = |(w_pulse & (w_pulse - 4'd1));
    assign w_b_full = {r_b[7:4], bus.q};

    always_comb begin
        w_accept = 1'b0;
        if (!w_multi) begin
            case (r_state)
                IDLE, DONE: w_accept = w_pulse[0];
                GOT_AH:     w_accept = w_pulse[1];
                GOT_AL:     w_accept = w_pulse[2];
                GOT_BH:     w_accept = w_pulse[3];
                default:    w_accept = 1'b0;
            endcase
        end
    end

`ifdef COMP_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] r_to_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_lo    <= 1'b0;
            r_eo    <= 1'b0;
            r_go    <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
`ifdef COMP_SEQ_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
        end else if (w_any) begin
`ifdef COMP_SEQ_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
            // Every press leaves the current state, so the result is dropped unless DONE is re-entered.
            r_lo    <= 1'b0;
            r_eo    <= 1'b0;
            r_go    <= 1'b0;
            r_valid <= 1'b0;
            if (!w_accept) begin
                r_state <= IDLE;
                r_err   <= 1'b1;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        r_state  <= GOT_AH;
                        r_a[7:4] <= bus.q;
                        r_err    <= 1'b0;
                    end
                    GOT_AH: begin
                        r_state  <= GOT_AL;
                        r_a[3:0] <= bus.q;
                    end
                    GOT_AL: begin
                        r_state  <= GOT_BH;
                        r_b[7:4] <= bus.q;
                    end
                    GOT_BH: begin
                        r_state  <= DONE;
                        r_b[3:0] <= bus.q;
                        r_lo     <= (r_a <  w_b_full);
                        r_eo     <= (r_a == w_b_full);
                        r_go     <= (r_a >  w_b_full);
                        r_valid  <= 1'b1;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_err   <= 1'b1;
                    end
                endcase
            end
        end
`ifdef COMP_SEQ_TIMEOUT_EN
        else if (r_state == GOT_AH || r_state == GOT_AL || r_state == GOT_BH) begin
            if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                r_state  <= IDLE;
                r_err    <= 1'b1;
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
        end else begin
            r_to_cnt <= '0;
        end
`endif
    end

    assign bus.a     = r_a;
    assign bus.b     = r_b;
    assign bus.lo    = r_lo;
    assign bus.eo    = r_eo;
    assign bus.go    = r_go;
    assign bus.valid = r_valid;
    assign bus.err   = r_err;
    assign bus.state = r_state;

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Directed bench for comp_seq_ctrl with DEB_CYCLES=4, TIMEOUT_CYCLES=64.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_comp_seq_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    comp_seq_ctrl_if u_if();

    comp_seq_ctrl #(
        .DEB_CYCLES     (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    task automatic press(input int btn, input logic [3:0] qv);
        @(negedge clk);
        u_if.q       = qv;
        u_if.pb[btn] = 1'b1;
        repeat (10) @(negedge clk);
        u_if.pb[btn] = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        n_run++; if (u_if.a !== 8'h00) begin n_fail++; $display("FAIL rst_a got %h want 00", u_if.a); end
        n_run++; if (u_if.b !== 8'h00) begin n_fail++; $display("FAIL rst_b got %h want 00", u_if.b); end
        n_run++; if ({u_if.lo, u_if.eo, u_if.go, u_if.valid, u_if.err} !== 5'b0) begin n_fail++;
            $display("FAIL rst_flags got %b want 00000", {u_if.lo, u_if.eo, u_if.go, u_if.valid, u_if.err}); end
        n_run++; if (u_if.state !== 3'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", u_if.state); end
        rst_n = 1'b1;
    endtask

    task automatic test_ordered();
        press(0, 4'h0);
        n_run++; if (u_if.state !== 3'd1) begin n_fail++; $display("FAIL ord_state_ah got %0d want 1", u_if.state); end
        press(1, 4'h7);
        n_run++; if (u_if.state !== 3'd2) begin n_fail++; $display("FAIL ord_state_al got %0d want 2", u_if.state); end
        press(2, 4'hF);
        press(3, 4'h5);
        n_run++; if (u_if.a !== 8'h07) begin n_fail++; $display("FAIL ord_a got %h want 07", u_if.a); end
        n_run++; if (u_if.b !== 8'hF5) begin n_fail++; $display("FAIL ord_b got %h want f5", u_if.b); end
        n_run++; if ({u_if.lo, u_if.eo, u_if.go} !== 3'b100) begin n_fail++;
            $display("FAIL ord_cmp got %b want 100", {u_if.lo, u_if.eo, u_if.go}); end
        n_run++; if (u_if.valid !== 1'b1) begin n_fail++; $display("FAIL ord_valid got %b want 1", u_if.valid); end
        n_run++; if (u_if.state !== 3'd4) begin n_fail++; $display("FAIL ord_state got %0d want 4", u_if.state); end
    endtask

    task automatic test_equal_then_new();
        press(0, 4'h3); press(1, 4'hC); press(2, 4'h3); press(3, 4'hC);
        n_run++; if ({u_if.lo, u_if.eo, u_if.go, u_if.valid} !== 4'b0101) begin n_fail++;
            $display("FAIL eq_cmp got %b want 0101", {u_if.lo, u_if.eo, u_if.go, u_if.valid}); end
        press(0, 4'h8);
        n_run++; if ({u_if.state, u_if.valid, u_if.eo} !== {3'd1, 2'b00}) begin n_fail++;
            $display("FAIL renew_state_valid got %0d/%b/%b want 1/0/0", u_if.state, u_if.valid, u_if.eo); end
        n_run++; if ({u_if.a, u_if.b} !== 16'h8C3C) begin n_fail++;
            $display("FAIL renew_ab got %h want 8c3c", {u_if.a, u_if.b}); end
        press(1, 4'h0); press(2, 4'h7); press(3, 4'hF);
        n_run++; if ({u_if.a, u_if.b} !== 16'h807F) begin n_fail++;
            $display("FAIL gt_ab got %h want 807f", {u_if.a, u_if.b}); end
        n_run++; if ({u_if.lo, u_if.eo, u_if.go, u_if.valid} !== 4'b0011) begin n_fail++;
            $display("FAIL gt_cmp got %b want 0011", {u_if.lo, u_if.eo, u_if.go, u_if.valid}); end
    endtask

    task automatic test_seq_error();
        press(0, 4'hA);
        press(2, 4'h3);
        n_run++; if ({u_if.state, u_if.err, u_if.valid} !== {3'd0, 2'b10}) begin n_fail++;
            $display("FAIL seqerr_state got %0d/%b/%b want 0/1/0", u_if.state, u_if.err, u_if.valid); end
        n_run++; if (u_if.a !== 8'hA0) begin n_fail++; $display("FAIL seqerr_a got %h want a0", u_if.a); end
        press(0, 4'h1);
        n_run++; if ({u_if.state, u_if.err} !== {3'd1, 1'b0}) begin n_fail++;
            $display("FAIL seqerr_clear got %0d/%b want 1/0", u_if.state, u_if.err); end
    endtask

    task automatic test_bounce();
        do_reset();
        u_if.q = 4'h6;
        for (int k = 0; k < 3; k++) begin
            u_if.pb[0] = 1'b1;
            repeat (2) @(negedge clk);
            u_if.pb[0] = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        n_run++; if (u_if.state !== 3'd0) begin n_fail++; $display("FAIL bounce_none got %0d want 0", u_if.state); end
        u_if.pb[0] = 1'b1;
        repeat (10) @(negedge clk);
        u_if.pb[0] = 1'b0;
        repeat (10) @(negedge clk);
        n_run++; if ({u_if.state, u_if.err, u_if.a} !== {3'd1, 1'b0, 8'h60}) begin n_fail++;
            $display("FAIL bounce_one got %0d/%b/%h want 1/0/60", u_if.state, u_if.err, u_if.a); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        @(negedge clk);
        u_if.q  = 4'h2;
        u_if.pb = 4'b0011;
        repeat (10) @(negedge clk);
        u_if.pb = 4'b0000;
        repeat (10) @(negedge clk);
        n_run++; if ({u_if.state, u_if.err} !== {3'd0, 1'b1}) begin n_fail++;
            $display("FAIL simul got %0d/%b want 0/1", u_if.state, u_if.err); end
    endtask

    task automatic test_async_reset();
        press(0, 4'h1); press(1, 4'h2); press(2, 4'h3);
        n_run++; if ({u_if.state, u_if.b} !== {3'd3, 8'h30}) begin n_fail++;
            $display("FAIL pre_rst got %0d/%h want 3/30", u_if.state, u_if.b); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_run++; if ({u_if.a, u_if.b} !== 16'h0000) begin n_fail++;
            $display("FAIL arst_ab got %h want 0000", {u_if.a, u_if.b}); end
        n_run++; if ({u_if.state, u_if.lo, u_if.eo, u_if.go, u_if.valid, u_if.err} !== 8'h00) begin n_fail++;
            $display("FAIL arst_state got %0d flags %b want 0", u_if.state,
                     {u_if.lo, u_if.eo, u_if.go, u_if.valid, u_if.err}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        press(0, 4'h9);
        repeat (40) @(negedge clk);
        n_run++; if (u_if.state !== 3'd1) begin n_fail++; $display("FAIL to_wait got %0d want 1", u_if.state); end
`ifdef COMP_SEQ_TIMEOUT_EN
        repeat (30) @(negedge clk);
        n_run++; if ({u_if.state, u_if.err, u_if.a} !== {3'd0, 1'b1, 8'h90}) begin n_fail++;
            $display("FAIL to_expire got %0d/%b/%h want 0/1/90", u_if.state, u_if.err, u_if.a); end
`else
        repeat (160) @(negedge clk);
        n_run++; if ({u_if.state, u_if.err} !== {3'd1, 1'b0}) begin n_fail++;
            $display("FAIL to_none got %0d/%b want 1/0", u_if.state, u_if.err); end
`endif
    endtask

    initial begin
        u_if.pb = 4'b0000;
        u_if.q  = 4'h0;
        test_reset();
        test_ordered();
        test_equal_then_new();
        test_seq_error();
        test_bounce();
        test_simultaneous();
        test_async_reset();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
